// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, constants and round-robin helper for the display source scheduler
package display_pkg;

  localparam int NSRC = 4;
  localparam logic [4:0] BLANK_CODE = 5'b10000;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // First requester after cur (wrapping); cur itself is checked last, and is kept if nobody requests.
  function automatic logic [1:0] next_rr(input logic [NSRC-1:0] req, input logic [1:0] cur);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = cur + k[1:0];
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability counter and one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk100M,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0;
  logic          sync1;
  logic          level;
  logic [CW-1:0] cnt;
  logic          accept;

  // accept fires on the last of DEBOUNCE_CYCLES consecutive differing samples
  assign accept = (sync1 != level) && (cnt == CNT_LAST);
  assign press  = accept && sync1;

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_source_scheduler.sv
// rtl/display_source_scheduler.sv - round-robin sharing of the 4-digit display between four sources
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES    = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit LZ_BLANK        = 1'b1
) (
  input  logic              clk100M,
  input  logic              rst,
  input  logic [NSRC-1:0]   req,
  input  logic [16*NSRC-1:0] val_bus,
  input  logic              auto_mode,
  input  logic              btn_next,
  output logic [NSRC-1:0]   gnt,
  output logic [1:0]        src_idx,
  output logic [4:0]        AN3,
  output logic [4:0]        AN2,
  output logic [4:0]        AN1,
  output logic [4:0]        AN0
);

  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  state_t          state;
  logic [DW_W-1:0] dwell;
  logic            press;
  logic            expire;
  logic            advance;
  logic [1:0]      nxt;
  logic [15:0]     cur_val;
  logic [4:0]      d3, d2, d1, d0;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk100M (clk100M),
    .rst     (rst),
    .btn_raw (btn_next),
    .press   (press)
  );

  assign nxt     = next_rr(req, src_idx);
  assign expire  = auto_mode && (dwell == DWELL_LAST);
  // a dropped request re-arbitrates exactly like a press or dwell expiry
  assign advance = press || expire || !req[src_idx];

  always_comb begin
    cur_val = val_bus[{src_idx, 4'b0000} +: 16];
    d3 = {1'b0, cur_val[15:12]};
    d2 = {1'b0, cur_val[11:8]};
    d1 = {1'b0, cur_val[7:4]};
    d0 = {1'b0, cur_val[3:0]};
    if (LZ_BLANK) begin
      if (cur_val[15:12] == 4'h0) d3 = BLANK_CODE;
      if (cur_val[15:8] == 8'h00) d2 = BLANK_CODE;
      if (cur_val[15:4] == 12'h000) d1 = BLANK_CODE;
    end
    if (state == IDLE) begin
      d3 = BLANK_CODE;
      d2 = BLANK_CODE;
      d1 = BLANK_CODE;
      d0 = BLANK_CODE;
    end
  end

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      src_idx <= 2'd0;
      dwell   <= '0;
      AN3     <= BLANK_CODE;
      AN2     <= BLANK_CODE;
      AN1     <= BLANK_CODE;
      AN0     <= BLANK_CODE;
    end else begin
      AN3 <= d3;
      AN2 <= d2;
      AN1 <= d1;
      AN0 <= d0;
      case (state)
        IDLE: begin
          dwell <= '0;
          if (req != '0) begin
            state   <= SHOW;
            src_idx <= nxt;
            gnt     <= 4'b0001 << nxt;
          end
        end
        SHOW: begin
          if (req == '0) begin
            state <= IDLE;
            gnt   <= '0;
            dwell <= '0;
          end else if (advance) begin
            src_idx <= nxt;
            gnt     <= 4'b0001 << nxt;
            dwell   <= '0;
          end else if (auto_mode) begin
            dwell <= dwell + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Shares the 4-digit 7-segment display between 4 requesters (e.g. PC, ALU result, register read, memory word), each presenting a 16-bit value.
- Grants one source at a time, round-robin. Advances on a dwell timer (auto mode) or on a debounced push-button press (manual mode).
- Drives the four 5-bit digit codes (AN3..AN0) consumed by the display scanner. Code bit 4 = 1 blanks the digit.

Parameters:
- NSRC, 4, number of requesters (fixed at 4; index width 2).
- DWELL_CYCLES, 100_000_000, clk100M cycles a source stays shown in auto mode (1 s).
- DEBOUNCE_CYCLES, 1_000_000, cycles btn_next must be stable before a level is accepted (10 ms).
- LZ_BLANK, 1, when 1, leading zero nibbles are blanked (the least-significant digit is never blanked).

Ports:
- clk100M  in  1  system clock, 100 MHz.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- req  in  4  per-source display request, level.
- val_bus  in  64  source values; source i = val_bus[16*i+15 : 16*i].
- auto_mode  in  1  1 = dwell-timer rotation, 0 = button rotation only.
- btn_next  in  1  raw, asynchronous push button.
- gnt  out  4  one-hot grant, or 0 when idle.
- src_idx  out  2  index of the granted source; holds last value when idle.
- AN3, AN2, AN1, AN0  out  5 each  digit codes. AN3 = val[15:12] … AN0 = val[3:0]. Blank code = 5'b10000.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, src_idx=0, AN3..AN0=5'b10000, dwell and debounce counters=0, debounced button level=0, button synchronizer flops=0.
- btn_next path:
  - 2-flop synchronizer, then a stability counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronized value.
  - A 0->1 change of the accepted level produces a one-cycle press pulse.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- State machine:
  - IDLE: gnt=0, all AN blank.
    - If req!=0, go to SHOW next edge.
    - gnt = first requesting source at or after (src_idx+1) mod 4, wrapping.
    - Dwell counter cleared.
  - SHOW: the granted source is displayed.
    - Advance event = press pulse, OR (auto_mode=1 AND dwell counter == DWELL_CYCLES-1).
    - On advance: choose the next requesting source searching from src_idx+1, wrapping. If the only requester is the current one, gnt is unchanged. Dwell counter is cleared on every advance.
    - If req[src_idx] drops: re-arbitrate on the next edge as an advance. If req==0, go to IDLE (gnt=0).
    - A press and dwell expiry in the same cycle produce exactly one advance.
    - A press while auto_mode=1 also advances and restarts the dwell.
  - Dwell counter runs only in SHOW with auto_mode=1. It holds its value when auto_mode=0. Width = clog2(DWELL_CYCLES).
- Display latency:
  - AN outputs are registered from the val_bus slice selected by the current gnt, so they lag gnt by 1 cycle.
  - The first cycle after entering SHOW shows the new source's value (never a stale mix of sources).
  - The value is live: changes on the granted slice appear 1 cycle later.
- Leading-zero blanking (LZ_BLANK=1):
  - AN3 is blank if nibble3==0.
  - AN2 is blank if nibble3 and nibble2 are 0.
  - AN1 is blank if nibbles 3..1 are 0.
  - AN0 always shows its nibble, with bit4=0.
- All AN outputs have bit4=0 except blanked digits.
- Reset mid-display: outputs blank immediately. After release, the first grant is to the lowest requesting index at or after 1 (src_idx=0 after reset, so the search starts at 1).

Decomposition:
- Shared package (display_pkg):
  - BLANK_CODE=5'b10000.
  - NSRC=4.
  - State encoding IDLE=1'b0, SHOW=1'b1.
  - A round-robin next-index function, next_rr(req, cur).
- One natural sub-module: btn_debounce (synchronizer + stability counter + press pulse), parameterized by DEBOUNCE_CYCLES.

Test Plan (sim parameters DWELL_CYCLES=8, DEBOUNCE_CYCLES=4):
- rst=1 with req=4'hF, then release → AN all 5'b10000 during reset. gnt=4'b0010 one edge after release. One cycle later AN3..AN0 = digits of source 1; with val1=16'h00A5, expect AN3=10000, AN2=10000, AN1=0_1010, AN0=0_0101.
- auto_mode=1, req=4'b1011 → gnt sequence 0010→1000→0001→0010, each held exactly 8 cycles; source 2 is never granted.
- auto_mode=0, btn_next pulses of 2 cycles → no advance. btn_next held high 10 cycles → exactly one advance, 4+2 cycles after the rise. No advance from the dwell timer.
- Granted source 3 drops req while req=4'b1001 → next grant is 0001. Then req→0 → IDLE, gnt=0, AN blank next cycle.
- Dwell expiry and press pulse in the same cycle, with req=4'hF and src_idx=1 → src_idx=2 (not 3); dwell restarts at 0.
- Assert rst asynchronously mid-SHOW, between clock edges → gnt=0 and AN=5'b10000 immediately, without waiting for a clock edge.
